tft_draw_scheduler: RTL and testbench
=====================================

# tft_draw_scheduler

Shares the single TFT byte link between the power-up init sequencer and two region-drawing clients: client 0 is the full-scene drawer, client 1 is the sprite/tile drawer. After init completes, the block arbitrates between the drawing clients round-robin. For each grant it emits the panel window commands (column set, page set, memory write) for the winner's rectangle, then passes that client's pixel byte stream through to the TFT sender until the client releases. It sits between the drawing clients and the TFT byte transmitter.

## Interface
Parameters:
- CMD_CASET, 8'h2A, column-address-set opcode
- CMD_PASET, 8'h2B, page-address-set opcode
- CMD_RAMWR, 8'h2C, memory-write opcode

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- init_done  in  1  init sequencer finished; sampled, sticky internally
- init_data  in  8  init byte
- init_dc  in  1  init D/C
- init_transmit  in  1  init byte strobe
- tft_busy  in  1  TFT sender busy; rises the cycle after an accepted strobe
- req  in  2  per-client draw request, level, held until done
- win_x0, win_x1  in  18  packed per-client column bounds, 9 bits each, client i at [9i+8:9i]
- win_y0, win_y1  in  18  packed per-client row bounds, 9 bits each
- cli_data  in  16  packed per-client pixel bytes
- cli_transmit  in  2  per-client pixel strobes
- grant  out  2  one-hot grant, registered
- tft_data  out  8  byte to TFT sender
- tft_dc  out  1  0 = command, 1 = data
- tft_transmit  out  1  one-cycle byte strobe
- busy  out  1  high in every state except IDLE

## Operation
- States: WAIT_INIT, IDLE, ARB, CMD, DRAIN, GRANT, RELEASE.
- **WAIT_INIT** (after reset):
  - tft_data, tft_dc and tft_transmit combinationally follow the init_* inputs.
  - grant = 0.
  - When init_done = 1, move to IDLE. init_done is sticky internally.
- **IDLE**:
  - Outputs: tft_transmit 0, tft_dc 1, tft_data holds its last value.
  - If any req bit is set, go to ARB.
- **ARB** (1 cycle):
  - Pick the winner round-robin. If both clients request, choose the one not equal to last_grant; otherwise choose the single requester.
  - Latch the winner's x0, x1, y0 and y1.
  - Set last_grant to the winner. last_grant resets to 1, so client 0 wins the first tie.
  - Clear seq to 0 and go to CMD.
- **CMD**: emit 11 bytes in order:
  1. CASET (dc 0)
  2. {7'b0, x0[8]}
  3. x0[7:0]
  4. {7'b0, x1[8]}
  5. x1[7:0]
  6. PASET (dc 0)
  7. y0 high byte
  8. y0 low byte
  9. y1 high byte
  10. y1 low byte
  11. RAMWR (dc 0)
  - Bytes 2–5 and 7–10 carry dc 1.
  - tft_data and tft_dc are registered.
  - A byte is launched only when tft_busy = 0 and tft_transmit was 0 in the previous cycle. tft_transmit is high for exactly one cycle per byte.
  - seq increments on each launch. After byte 11, go to DRAIN.
- **DRAIN**: wait for tft_busy = 0 with tft_transmit = 0, then set grant[winner] and go to GRANT.
- **GRANT**:
  - tft_data = cli_data of the winner and tft_transmit = cli_transmit of the winner, both combinational. tft_dc is forced to 1.
  - Strobes from the non-granted client are ignored.
  - Pacing is the client's responsibility: strobe only when tft_busy = 0.
  - When req[winner] = 0, clear grant and go to RELEASE.
- **RELEASE**: wait for tft_busy = 0, then go to IDLE.
- Window bounds are sent unchecked; x1 < x0 is passed through unchanged.
- The request of the non-granted client stays pending and wins the next ARB.

## Timing
- Reset values: grant 0, tft_transmit 0, tft_data 8'h00, tft_dc 1, busy 1 (WAIT_INIT), last_grant 1, seq 0.
- Pass-through (WAIT_INIT, GRANT) has zero latency.
- ARB is 1 cycle.
- Idle-sender minimum from req to grant: 1 (IDLE→ARB) + 1 (ARB) + 11×2 (CMD) + 2 (DRAIN) = 26 cycles. With a real sender it is 11 × byte time plus overhead.
- The byte interval in CMD is at least 2 cycles, because tft_transmit must be low the cycle before a launch.
- Both req bits rising in the same IDLE cycle: the round-robin rule applies.
- A req drop during ARB, CMD or DRAIN is ignored; the window sequence completes, grant asserts, and the grant is released on the next cycle.
- rst mid-operation: return to WAIT_INIT next cycle and clear all outputs to their reset values. init_done must be re-seen.

## Test plan
- **Init pass-through:** init_done 0, drive init_data 8'h11, dc 0, strobe. Expect tft_data 8'h11, dc 0, same-cycle strobe, grant 00. Then init_done 1 → IDLE, busy 0.
- **Window sequence:** client 0 req with x 0..319, y 0..479, idle sender. Expect bytes 2A, 00, 00, 01, 3F, 2B, 00, 00, 01, DF, 2C with dc pattern 0,1,1,1,1,0,1,1,1,1,0, then grant 01.
- **Round-robin:** both req set in the same cycle after reset. Expect client 0 granted first. Drop req0; expect client 1 granted next, with client 1's window bytes.
- **Isolation:** with client 0 granted, client 1 strobes 8'hAA. Expect no tft_transmit. Client 0 strobe 8'h55 → tft_data 8'h55, dc 1.
- **Busy backpressure:** hold tft_busy 1 for 5 cycles mid-CMD. Expect no strobe while busy, the sequence resumes at the same seq, and no byte is duplicated or lost.
- **Reset mid-CMD:** assert rst after byte 4. Expect grant 00, tft_transmit 0, return to WAIT_INIT. Re-init then a req restarts from byte 2A.

Source files
------------

// File: rtl/tft_draw_scheduler.sv
// tft_draw_scheduler: shares the TFT byte link between init and two round-robin drawing clients
module tft_draw_scheduler #(
  parameter logic [7:0] CMD_CASET = 8'h2A,
  parameter logic [7:0] CMD_PASET = 8'h2B,
  parameter logic [7:0] CMD_RAMWR = 8'h2C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic [7:0]  init_data,
  input  logic        init_dc,
  input  logic        init_transmit,
  input  logic        tft_busy,
  input  logic [1:0]  req,
  input  logic [17:0] win_x0,
  input  logic [17:0] win_x1,
  input  logic [17:0] win_y0,
  input  logic [17:0] win_y1,
  input  logic [15:0] cli_data,
  input  logic [1:0]  cli_transmit,
  output logic [1:0]  grant,
  output logic [7:0]  tft_data,
  output logic        tft_dc,
  output logic        tft_transmit,
  output logic        busy
);
  typedef enum logic [2:0] {WAIT_INIT, IDLE, ARB, CMD, DRAIN, GRANT, RELEASE} state_t;
  state_t state, state_nx;
  logic       last;
  logic [8:0] x0, x1, y0, y1;
  logic [3:0] seq;
  logic [7:0] data_r, cmd_byte, cli_byte;
  logic       dc_r, tx_r, cmd_dc, win, launch;
  assign win      = &req ? ~last : req[1];
  assign launch   = state == CMD && !tft_busy && !tx_r;
  assign cli_byte = last ? cli_data[15:8] : cli_data[7:0];
  assign busy     = state != IDLE;
  // window command byte selected by the sequence position
  always_comb begin
    cmd_byte = CMD_RAMWR;
    case (seq)
      4'd0: cmd_byte = CMD_CASET;
      4'd1: cmd_byte = {7'b0, x0[8]};
      4'd2: cmd_byte = x0[7:0];
      4'd3: cmd_byte = {7'b0, x1[8]};
      4'd4: cmd_byte = x1[7:0];
      4'd5: cmd_byte = CMD_PASET;
      4'd6: cmd_byte = {7'b0, y0[8]};
      4'd7: cmd_byte = y0[7:0];
      4'd8: cmd_byte = {7'b0, y1[8]};
      4'd9: cmd_byte = y1[7:0];
      default: cmd_byte = CMD_RAMWR;
    endcase
    cmd_dc = !(seq == 4'd0 || seq == 4'd5 || seq == 4'd10);
  end
  // state register
  always_ff @(posedge clk) state <= rst ? WAIT_INIT : state_nx;
  // next-state logic; leaving WAIT_INIT makes init_done sticky
  always_comb begin
    state_nx = state;
    case (state)
      WAIT_INIT: state_nx = init_done ? IDLE : WAIT_INIT;
      IDLE:      state_nx = |req ? ARB : IDLE;
      ARB:       state_nx = CMD;
      CMD:       state_nx = launch && seq == 4'd10 ? DRAIN : CMD;
      DRAIN:     state_nx = !tft_busy && !tx_r ? GRANT : DRAIN;
      GRANT:     state_nx = !req[last] ? RELEASE : GRANT;
      RELEASE:   state_nx = !tft_busy ? IDLE : RELEASE;
      default:   state_nx = WAIT_INIT;
    endcase
  end
  // arbitration, window latch, command launch and grant registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last   <= 1'b1;
      seq    <= '0;
      data_r <= '0;
      dc_r   <= 1'b1;
      tx_r   <= 1'b0;
      grant  <= '0;
      x0     <= '0;
      x1     <= '0;
      y0     <= '0;
      y1     <= '0;
    end else begin
      tx_r <= launch;
      if (launch) begin
        data_r <= cmd_byte;
        dc_r   <= cmd_dc;
        seq    <= seq + 4'd1;
      end
      if (state == ARB) begin
        last <= win;
        seq  <= '0;
        x0   <= win ? win_x0[17:9] : win_x0[8:0];
        x1   <= win ? win_x1[17:9] : win_x1[8:0];
        y0   <= win ? win_y0[17:9] : win_y0[8:0];
        y1   <= win ? win_y1[17:9] : win_y1[8:0];
      end
      if (state == WAIT_INIT && init_transmit) data_r <= init_data;
      if (state == GRANT && cli_transmit[last]) data_r <= cli_byte;
      if (state == DRAIN && state_nx == GRANT) grant <= last ? 2'b10 : 2'b01;
      if (state == GRANT && !req[last]) grant <= '0;
    end
  end
  // output mux: init and granted client pass through, otherwise the command registers
  always_comb begin
    tft_data     = state == WAIT_INIT ? init_data : state == GRANT ? cli_byte : data_r;
    tft_dc       = state == WAIT_INIT ? init_dc : (state == CMD || state == DRAIN) ? dc_r : 1'b1;
    tft_transmit = state == WAIT_INIT ? init_transmit : state == GRANT ? cli_transmit[last] : tx_r;
  end
endmodule

// File: tb/tb_tft_draw_scheduler.sv
// tb_tft_draw_scheduler: directed checks of init pass-through, window commands, arbitration and reset
module tb_tft_draw_scheduler;
  logic        clk = 0, rst = 1, init_done = 0, init_dc = 0, init_transmit = 0, tft_busy = 0;
  logic [7:0]  init_data = 0;
  logic [1:0]  req = 0, cli_transmit = 0, grant;
  logic [17:0] win_x0 = 0, win_x1 = 0, win_y0 = 0, win_y1 = 0;
  logic [15:0] cli_data = 0;
  logic [7:0]  tft_data;
  logic        tft_dc, tft_transmit, busy;
  int total = 0, bad = 0;
  localparam logic [87:0] WIN_A = 88'h2A_00_00_01_3F_2B_00_00_01_DF_2C;
  localparam logic [87:0] WIN_B = 88'h2A_00_0A_01_09_2B_01_2C_00_05_2C;
  localparam logic [10:0] DC_PAT = 11'b01111011110;
  tft_draw_scheduler dut (
    .clk(clk), .rst(rst), .init_done(init_done), .init_data(init_data), .init_dc(init_dc),
    .init_transmit(init_transmit), .tft_busy(tft_busy), .req(req), .win_x0(win_x0),
    .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1), .cli_data(cli_data),
    .cli_transmit(cli_transmit), .grant(grant), .tft_data(tft_data), .tft_dc(tft_dc),
    .tft_transmit(tft_transmit), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic collect(input string tag, input logic [87:0] ed, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      logic got;
      got = 0;
      for (int k = 0; k < 40 && !got; k++) begin
        step();
        if (tft_transmit) got = 1;
      end
      chk($sformatf("%s byte%0d strobe", tag, i), {31'd0, got}, 32'd1);
      if (got) begin
        chk($sformatf("%s byte%0d data", tag, i), {24'd0, tft_data}, {24'd0, ed[8*(10-i) +: 8]});
        chk($sformatf("%s byte%0d dc", tag, i), {31'd0, tft_dc}, {31'd0, DC_PAT[10-i]});
      end
    end
  endtask
  task automatic wait_grant(input string tag, input logic [1:0] exp);
    for (int k = 0; k < 10 && grant == 2'b00; k++) step();
    chk(tag, {30'd0, grant}, {30'd0, exp});
  endtask
  task automatic reinit();
    rst = 1;
    step();
    rst = 0;
    init_done = 1;
    step();
    init_done = 0;
  endtask
  initial begin
    win_x0 = {9'd10, 9'd0};
    win_x1 = {9'd265, 9'd319};
    win_y0 = {9'd300, 9'd0};
    win_y1 = {9'd5, 9'd479};
    cli_data = {8'hAA, 8'h55};
    step();
    step();
    chk("reset grant", {30'd0, grant}, 0);
    chk("reset busy", {31'd0, busy}, 1);
    chk("reset strobe", {31'd0, tft_transmit}, 0);
    rst = 0;
    init_data = 8'h11;
    init_dc = 0;
    init_transmit = 1;
    #1;
    chk("init data", {24'd0, tft_data}, 32'h11);
    chk("init dc", {31'd0, tft_dc}, 0);
    chk("init strobe", {31'd0, tft_transmit}, 1);
    chk("init grant", {30'd0, grant}, 0);
    step();
    init_transmit = 0;
    init_done = 1;
    step();
    init_done = 0;
    chk("idle busy", {31'd0, busy}, 0);
    chk("idle dc", {31'd0, tft_dc}, 1);
    chk("idle strobe", {31'd0, tft_transmit}, 0);
    chk("idle data hold", {24'd0, tft_data}, 32'h11);
    req = 2'b01;
    collect("winA", WIN_A, 0, 10);
    wait_grant("winA grant", 2'b01);
    cli_transmit = 2'b10;
    #1;
    chk("isolation strobe", {31'd0, tft_transmit}, 0);
    cli_transmit = 2'b01;
    #1;
    chk("pass strobe", {31'd0, tft_transmit}, 1);
    chk("pass data", {24'd0, tft_data}, 32'h55);
    chk("pass dc", {31'd0, tft_dc}, 1);
    step();
    cli_transmit = 0;
    req = 0;
    step();
    chk("release grant", {30'd0, grant}, 0);
    step();
    chk("back idle", {31'd0, busy}, 0);
    reinit();
    req = 2'b11;
    collect("rr first", WIN_A, 0, 10);
    wait_grant("rr first grant", 2'b01);
    req = 2'b10;
    step();
    chk("rr release", {30'd0, grant}, 0);
    collect("rr second", WIN_B, 0, 10);
    wait_grant("rr second grant", 2'b10);
    req = 0;
    step();
    step();
    req = 2'b01;
    collect("bp pre", WIN_A, 0, 2);
    tft_busy = 1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("bp hold%0d", k), {31'd0, tft_transmit}, 0);
    end
    tft_busy = 0;
    collect("bp post", WIN_A, 3, 10);
    wait_grant("bp grant", 2'b01);
    req = 0;
    step();
    step();
    req = 2'b01;
    collect("rst pre", WIN_A, 0, 3);
    rst = 1;
    step();
    chk("rst grant", {30'd0, grant}, 0);
    chk("rst strobe", {31'd0, tft_transmit}, 0);
    chk("rst busy", {31'd0, busy}, 1);
    rst = 0;
    step();
    step();
    chk("rst wait init", {31'd0, busy}, 1);
    init_done = 1;
    collect("rst restart", WIN_A, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
